// File: rtl/inst_fetch_align_pkg.sv
// Shared definitions for the instruction fetch/align front end:
// supported opcodes, fetch FSM states and the opcode length table.
package inst_pkg;

    localparam logic [7:0] OP_PUSH_EBP    = 8'h55;
    localparam logic [7:0] OP_MOV_RR      = 8'h89;
    localparam logic [7:0] OP_MOV_EAX_IMM = 8'hb8;
    localparam logic [7:0] OP_POP_EBP     = 8'h5d;
    localparam logic [7:0] OP_RET         = 8'hc3;
    localparam logic [7:0] OP_CALL        = 8'he8;

    typedef enum logic [1:0] {
        ST_OP   = 2'd0,
        ST_ARG  = 2'd1,
        ST_OUT  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    typedef struct packed {
        logic       legal;
        logic [2:0] len;
    } op_info_t;

    // Length in bytes of an instruction given its opcode; unknown opcodes
    // come back with legal=0 and len=0.
    function automatic op_info_t op_length(input logic [7:0] opc);
        op_info_t info;
        info.legal = 1'b1;
        info.len   = 3'd0;
        case (opc)
            OP_PUSH_EBP, OP_POP_EBP, OP_RET: info.len = 3'd1;
            OP_MOV_RR:                       info.len = 3'd2;
            OP_MOV_EAX_IMM, OP_CALL:         info.len = 3'd5;
            default:                         info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/inst_fetch_align_op_length_decode.sv
// Combinational opcode length decoder, kept separate so a later decode
// stage can reuse the same table.
module op_length_decode
    import inst_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic       legal_o,
    output logic [2:0] len_o
);

    op_info_t info;

    // Look the opcode up in the shared length table.
    always_comb begin
        info    = op_length(opcode_i);
        legal_o = info.legal;
        len_o   = info.len;
    end

endmodule

// File: rtl/inst_fetch_align.sv
// Instruction fetch/align: reads the byte stream one byte per transfer,
// packs each instruction into a 32-bit word for the ALU and owns the
// fetch PC, including call/ret redirects.
module inst_fetch_align
    import inst_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_ack,
    output logic [31:0] ope,
    output logic [2:0]  ope_len,
    output logic [31:0] ope_pc,
    output logic        ope_valid,
    input  logic        ope_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        rd_q, rd_d;
    logic [31:0] ope_q, ope_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] opc_pc_q, opc_pc_d;
    logic [2:0]  rem_q, rem_d;
    logic        illegal_q, illegal_d;

    logic        dec_legal;
    logic [2:0]  dec_len;
    logic        take;
    logic        xfer;
    logic [2:0]  slot;

    op_length_decode u_dec (
        .opcode_i (mem_data),
        .legal_o  (dec_legal),
        .len_o    (dec_len)
    );

    // A byte that arrives alongside a redirect belongs to the abandoned stream.
    assign take = rd_q && mem_ack && !redirect;
    assign xfer = (state_q == ST_OUT) && ope_ready;
    // Operand byte position: 0..2 land in ope, 3 is the dropped 5th byte.
    assign slot = len_q - rem_q - 3'd1;

    // Next-state, PC and packing logic; redirect overrides everything.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ope_d     = ope_q;
        len_d     = len_q;
        opc_pc_d  = opc_pc_q;
        rem_d     = rem_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_OP: begin
                if (take) begin
                    ope_d    = {mem_data, 24'h00_0000};
                    opc_pc_d = pc_q;
                    len_d    = dec_len;
                    pc_d     = pc_q + 32'd1;
                    if (!dec_legal) begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end else begin
                        rem_d   = dec_len - 3'd1;
                        state_d = (dec_len == 3'd1) ? ST_OUT : ST_ARG;
                    end
                end
            end
            ST_ARG: begin
                if (take) begin
                    pc_d  = pc_q + 32'd1;
                    rem_d = rem_q - 3'd1;
                    case (slot)
                        3'd0:    ope_d[23:16] = mem_data;
                        3'd1:    ope_d[15:8]  = mem_data;
                        3'd2:    ope_d[7:0]   = mem_data;
                        default: ope_d        = ope_q;
                    endcase
                    if (rem_q == 3'd1) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (xfer) begin
                    pc_d    = opc_pc_q + {29'd0, len_q};
                    state_d = ST_OP;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        if (redirect) begin
            state_d   = ST_OP;
            pc_d      = redirect_pc;
            illegal_d = 1'b0;
        end
        rd_d = (state_d == ST_OP) || (state_d == ST_ARG);
    end

    // State and datapath registers; reset also drops any read in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_OP;
            pc_q      <= RESET_PC;
            rd_q      <= 1'b0;
            ope_q     <= 32'h0;
            len_q     <= 3'd0;
            opc_pc_q  <= 32'h0;
            rem_q     <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            ope_q     <= ope_d;
            len_q     <= len_d;
            opc_pc_q  <= opc_pc_d;
            rem_q     <= rem_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem_addr  = pc_q;
    assign mem_rd    = rd_q;
    assign ope       = ope_q;
    assign ope_len   = len_q;
    assign ope_pc    = opc_pc_q;
    assign ope_valid = (state_q == ST_OUT);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_inst_fetch_align.sv
// Directed bench for inst_fetch_align with a zero-wait byte memory model.
module tb_inst_fetch_align;

    logic        clock;
    logic        reset_n;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic [31:0] ope;
    logic [2:0]  ope_len;
    logic [31:0] ope_pc;
    logic        ope_valid;
    logic        ope_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        illegal;

    logic        ack_en;
    logic [7:0]  mem [0:255];

    typedef struct {
        logic [31:0] ope;
        logic [2:0]  len;
        logic [31:0] pc;
    } xfer_t;

    xfer_t       xq[$];
    logic [31:0] raddr[$];

    int errors = 0;
    int checks = 0;

    inst_fetch_align #(.RESET_PC(32'h0000_0100)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ack     (mem_ack),
        .ope         (ope),
        .ope_len     (ope_len),
        .ope_pc      (ope_pc),
        .ope_valid   (ope_valid),
        .ope_ready   (ope_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .illegal     (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Zero-wait memory: 256-byte image aliased on the low address byte.
    assign mem_data = mem[mem_addr[7:0]];
    assign mem_ack  = ack_en & mem_rd;

    // Log transfers and consumed byte addresses mid-cycle.
    always @(negedge clock) begin
        xfer_t x;
        if (reset_n && ope_valid && ope_ready) begin
            x.ope = ope;
            x.len = ope_len;
            x.pc  = ope_pc;
            xq.push_back(x);
        end
        if (reset_n && mem_rd && mem_ack && !redirect)
            raddr.push_back(mem_addr);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int k;
        k = 0;
        while (xq.size() < n && k < budget) begin
            cyc();
            k++;
        end
        ack_en = 1'b0;
        chk("xfer_wait", 32'(xq.size() >= n), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        cyc();
        redirect    = 1'b0;
    endtask

    initial begin
        logic hold_ok;
        int   k;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h55; mem[1] = 8'h89; mem[2] = 8'he5; mem[3] = 8'hb8;
        mem[4] = 8'h01; mem[5] = 8'h02; mem[6] = 8'h03; mem[7] = 8'h04;
        mem[8] = 8'hc3;
        reset_n     = 1'b0;
        ack_en      = 1'b0;
        ope_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset values
        repeat (3) cyc();
        chk("rst_addr",    mem_addr, 32'h0000_0100);
        chk("rst_rd",      32'(mem_rd), 32'd0);
        chk("rst_ope",     ope, 32'h0);
        chk("rst_len",     32'(ope_len), 32'd0);
        chk("rst_pc",      ope_pc, 32'h0);
        chk("rst_valid",   32'(ope_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_rd_low", 32'(mem_rd), 32'd0);
        cyc();
        chk("rel_rd_high", 32'(mem_rd), 32'd1);
        chk("rel_addr",    mem_addr, 32'h0000_0100);
        chk("rel_valid",   32'(ope_valid), 32'd0);
        chk("rel_illegal", 32'(illegal), 32'd0);

        // Program stream from address 0, ack in the redirect cycle dropped
        ack_en = 1'b1;
        do_redirect(32'h0);
        xq.delete();
        raddr.delete();
        wait_xfers(4, 60);
        chk("p0_ope", xq[0].ope, 32'h5500_0000);
        chk("p0_len", 32'(xq[0].len), 32'd1);
        chk("p0_pc",  xq[0].pc, 32'h0);
        chk("p1_ope", xq[1].ope, 32'h89e5_0000);
        chk("p1_len", 32'(xq[1].len), 32'd2);
        chk("p1_pc",  xq[1].pc, 32'h1);
        chk("p2_ope", xq[2].ope, 32'hb801_0203);
        chk("p2_len", 32'(xq[2].len), 32'd5);
        chk("p2_pc",  xq[2].pc, 32'h3);
        chk("p3_ope", xq[3].ope, 32'hc300_0000);
        chk("p3_len", 32'(xq[3].len), 32'd1);
        chk("p3_pc",  xq[3].pc, 32'h8);
        chk("p_nreads", 32'(raddr.size()), 32'd9);
        chk("p_read7",  raddr[7], 32'h7);
        chk("p_next_addr", mem_addr, 32'h9);

        // Backpressure: hold for 10 cycles, then exactly one transfer
        mem[9] = 8'h89; mem[10] = 8'h12;
        ope_ready = 1'b0;
        xq.delete();
        ack_en = 1'b1;
        k = 0;
        while (!ope_valid && k < 20) begin
            cyc();
            k++;
        end
        ack_en = 1'b0;
        chk("bp_valid", 32'(ope_valid), 32'd1);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(ope === 32'h8912_0000 && ope_pc === 32'h9 && ope_len === 3'd2
                  && mem_rd === 1'b0 && ope_valid === 1'b1))
                hold_ok = 1'b0;
            cyc();
        end
        chk("bp_hold", 32'(hold_ok), 32'd1);
        chk("bp_none", 32'(xq.size()), 32'd0);
        ope_ready = 1'b1;
        repeat (4) cyc();
        chk("bp_one",   32'(xq.size()), 32'd1);
        chk("bp_pc",    xq[0].pc, 32'h9);
        chk("bp_addr",  mem_addr, 32'hb);
        chk("bp_valid0", 32'(ope_valid), 32'd0);

        // Redirect mid-way through a call instruction
        mem[8'h20] = 8'he8; mem[8'h21] = 8'h11; mem[8'h22] = 8'h22;
        mem[8'h23] = 8'h33; mem[8'h24] = 8'h44; mem[8'h40] = 8'hc3;
        do_redirect(32'h20);
        ack_en = 1'b1;
        cyc();
        cyc();
        chk("rd_mid_addr", mem_addr, 32'h22);
        xq.delete();
        do_redirect(32'h40);
        chk("rd_new_addr", mem_addr, 32'h40);
        chk("rd_new_rd",   32'(mem_rd), 32'd1);
        chk("rd_valid0",   32'(ope_valid), 32'd0);
        wait_xfers(1, 20);
        chk("rd_ope", xq[0].ope, 32'hc300_0000);
        chk("rd_pc",  xq[0].pc, 32'h40);

        // Illegal opcode halts fetch until redirected
        mem[8'h10] = 8'h90;
        ack_en = 1'b1;
        do_redirect(32'h10);
        xq.delete();
        cyc();
        chk("ill_flag",  32'(illegal), 32'd1);
        chk("ill_rd",    32'(mem_rd), 32'd0);
        chk("ill_valid", 32'(ope_valid), 32'd0);
        repeat (3) cyc();
        chk("ill_stay",  32'(illegal), 32'd1);
        chk("ill_rd2",   32'(mem_rd), 32'd0);
        chk("ill_nox",   32'(xq.size()), 32'd0);
        ack_en = 1'b0;
        do_redirect(32'h0);
        chk("ill_clear", 32'(illegal), 32'd0);
        chk("ill_rd3",   32'(mem_rd), 32'd1);
        chk("ill_addr",  mem_addr, 32'h0);
        ack_en = 1'b1;
        wait_xfers(1, 20);
        chk("ill_res_ope", xq[0].ope, 32'h5500_0000);
        chk("ill_res_pc",  xq[0].pc, 32'h0);

        // 5-byte instruction straddling the 32-bit address wrap
        mem[8'hfe] = 8'hb8; mem[8'hff] = 8'ha1;
        do_redirect(32'hffff_fffe);
        xq.delete();
        raddr.delete();
        ack_en = 1'b1;
        wait_xfers(1, 30);
        chk("wr_ope", xq[0].ope, 32'hb8a1_5589);
        chk("wr_len", 32'(xq[0].len), 32'd5);
        chk("wr_pc",  xq[0].pc, 32'hffff_fffe);
        chk("wr_nreads", 32'(raddr.size()), 32'd5);
        chk("wr_read1",  raddr[1], 32'hffff_ffff);
        chk("wr_read2",  raddr[2], 32'h0);
        chk("wr_read4",  raddr[4], 32'h2);
        chk("wr_addr",   mem_addr, 32'h3);
        xq.delete();
        ack_en = 1'b1;
        wait_xfers(1, 30);
        chk("wr_next_pc",  xq[0].pc, 32'h3);
        chk("wr_next_ope", xq[0].ope, 32'hb801_0203);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
